seq_divider: RTL and testbench

SEQ_DIVIDER -- requirements
Module: seq_divider

---
 rtl/seq_divider_if.sv | 23 ++
 rtl/seq_divider.sv | 101 ++++++++++
 tb/tb_seq_divider.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_divider_if.sv
// Request/result bundle for the sequential divider.
// The requester drives operands and start; the divider returns status and results.
interface seq_divider_if;
    logic        start;
    logic        is_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    modport master (
        output start, is_signed, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, is_signed, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_divider.sv
// Fixed-latency 32-bit restoring divider (signed/unsigned) with one iteration
// per clock, a sign-fixup cycle and a one-cycle done pulse.
module seq_divider (
    input  logic           clk,
    input  logic           reset,
    seq_divider_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_t;

    state_t      state;
    logic [4:0]  count;
    logic [31:0] part_rem;
    logic [31:0] quo_shift;
    logic [31:0] div_mag;
    logic        neg_quo;
    logic        neg_rem;
    logic        zero_div;

    logic [32:0] shifted;
    logic [32:0] trial;

    // The 33-bit working remainder: previous remainder shifted left with the
    // next dividend bit; a non-negative trial difference means the bit is 1.
    always_comb begin
        shifted = {part_rem, quo_shift[31]};
        trial   = shifted - {1'b0, div_mag};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            count           <= '0;
            part_rem        <= '0;
            quo_shift       <= '0;
            div_mag         <= '0;
            neg_quo         <= 1'b0;
            neg_rem         <= 1'b0;
            zero_div        <= 1'b0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.quotient    <= '0;
            bus.remainder   <= '0;
            bus.div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bus.done <= 1'b0;
                    if (bus.start) begin
                        quo_shift <= (bus.is_signed && bus.dividend[31]) ? -bus.dividend : bus.dividend;
                        div_mag   <= (bus.is_signed && bus.divisor[31])  ? -bus.divisor  : bus.divisor;
                        neg_quo   <= bus.is_signed && (bus.dividend[31] ^ bus.divisor[31]);
                        neg_rem   <= bus.is_signed && bus.dividend[31];
                        zero_div  <= (bus.divisor == 32'd0);
                        part_rem  <= '0;
                        count     <= '0;
                        bus.busy  <= 1'b1;
                        state     <= CALC;
                    end
                end
                CALC: begin
                    if (!trial[32]) begin
                        part_rem  <= trial[31:0];
                        quo_shift <= {quo_shift[30:0], 1'b1};
                    end else begin
                        part_rem  <= shifted[31:0];
                        quo_shift <= {quo_shift[30:0], 1'b0};
                    end
                    count <= count + 5'd1;
                    if (count == 5'd31) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    // A zero divisor leaves the dividend magnitude in the
                    // remainder, so the normal sign fixup restores the dividend.
                    bus.quotient    <= zero_div ? 32'hFFFF_FFFF :
                                       (neg_quo ? -quo_shift : quo_shift);
                    bus.remainder   <= neg_rem ? -part_rem : part_rem;
                    bus.div_by_zero <= zero_div;
                    bus.busy        <= 1'b0;
                    bus.done        <= 1'b1;
                    state           <= DONE;
                end
                DONE: begin
                    bus.done <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: an arithmetic reference model with
// cycle-count timing, checked every cycle, plus directed literal cases.
module tb_seq_divider;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    seq_divider_if bus ();

    seq_divider dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference result packed as {div_by_zero, quotient, remainder}.
    function automatic logic [64:0] ref_div(input logic s, input logic [31:0] a, input logic [31:0] b);
        longint      sa;
        longint      sb;
        logic [63:0] lq;
        logic [63:0] lr;
        if (b == 32'd0) return {1'b1, 32'hFFFF_FFFF, a};
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        lq = 64'(sa / sb);
        lr = 64'(sa % sb);
        return {1'b0, lq[31:0], lr[31:0]};
    endfunction

    task automatic checkValue(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Cycle-level model: phase counts clock edges since acceptance.
    int          phase;
    bit          model_on;
    logic [64:0] pending;
    logic [31:0] exp_q;
    logic [31:0] exp_r;
    logic        exp_dbz;

    initial begin
        phase    = -1;
        model_on = 1'b0;
        pending  = '0;
        exp_q    = '0;
        exp_r    = '0;
        exp_dbz  = 1'b0;
    end

    always @(posedge clk) begin
        if (reset) begin
            phase    = -1;
            exp_q    = '0;
            exp_r    = '0;
            exp_dbz  = 1'b0;
            model_on = 1'b1;
        end else if (model_on) begin
            if (phase < 0) begin
                if (bus.start) begin
                    phase   = 0;
                    pending = ref_div(bus.is_signed, bus.dividend, bus.divisor);
                end
            end else begin
                phase++;
                if (phase == 33) begin
                    {exp_dbz, exp_q, exp_r} = pending;
                end else if (phase == 34) begin
                    phase = -1;
                end
            end
        end
        #1;
        if (model_on) begin
            checkValue("busy",        32'(bus.busy),        32'(phase >= 0 && phase <= 32));
            checkValue("done",        32'(bus.done),        32'(phase == 33));
            checkValue("quotient",    bus.quotient,         exp_q);
            checkValue("remainder",   bus.remainder,        exp_r);
            checkValue("div_by_zero", 32'(bus.div_by_zero), 32'(exp_dbz));
        end
    end

    // Present one request for a single cycle, then scramble the operands so
    // the result can only come from the values latched at acceptance.
    task automatic applyStimulus(input logic s, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.start     = 1'b1;
        bus.is_signed = s;
        bus.dividend  = a;
        bus.divisor   = b;
        @(negedge clk);
        bus.start     = 1'b0;
        bus.is_signed = 1'($urandom);
        bus.dividend  = $urandom;
        bus.divisor   = $urandom;
    endtask

    // Wait (bounded) for done, then compare with the given expectation.
    task automatic checkOutput(input string name, input logic [64:0] exp,
                               output int latency, output int busy_cycles);
        int cycles;
        cycles      = 0;
        busy_cycles = bus.busy ? 1 : 0;
        while (!bus.done && cycles < 100) begin
            @(negedge clk);
            cycles++;
            if (bus.busy) busy_cycles++;
        end
        latency = cycles + 1;
        if (!bus.done) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s_timeout: got no done expected done within 100 cycles", name);
        end else begin
            checkValue({name, "_q"},   bus.quotient,         exp[63:32]);
            checkValue({name, "_r"},   bus.remainder,        exp[31:0]);
            checkValue({name, "_dbz"}, 32'(bus.div_by_zero), 32'(exp[64]));
        end
    endtask

    initial begin
        int          lat;
        int          bcy;
        int          dones;
        logic        s;
        logic [31:0] a;
        logic [31:0] b;

        errors        = 0;
        checks        = 0;
        reset         = 1'b1;
        bus.start     = 1'b0;
        bus.is_signed = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Pin the model to hand-computed values.
        checkValue("model_100_7", ref_div(1'b0, 32'd100, 32'd7) == {1'b0, 32'd14, 32'd2} ? 32'd1 : 32'd0, 32'd1);
        checkValue("model_m7_2",  ref_div(1'b1, 32'hFFFF_FFF9, 32'd2) == {1'b0, 32'hFFFF_FFFD, 32'hFFFF_FFFF} ? 32'd1 : 32'd0, 32'd1);

        checkValue("reset_quotient", bus.quotient, 32'd0);
        checkValue("reset_busy",     32'(bus.busy), 32'd0);

        applyStimulus(1'b0, 32'd100, 32'd7);
        checkOutput("u100_7", {1'b0, 32'd14, 32'd2}, lat, bcy);
        checkValue("u100_7_latency", 32'(lat), 32'd34);
        checkValue("u100_7_busy_cycles", 32'(bcy), 32'd33);

        applyStimulus(1'b1, 32'hFFFF_FFF9, 32'd2);
        checkOutput("sm7_2", {1'b0, 32'hFFFF_FFFD, 32'hFFFF_FFFF}, lat, bcy);

        applyStimulus(1'b0, 32'hFFFF_FFFF, 32'd0);
        checkOutput("u_div0", {1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF}, lat, bcy);
        checkValue("u_div0_latency", 32'(lat), 32'd34);

        applyStimulus(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        checkOutput("s_ovf", {1'b0, 32'h8000_0000, 32'd0}, lat, bcy);

        applyStimulus(1'b1, 32'hFFFF_FF9C, 32'd0);
        checkOutput("s_div0", {1'b1, 32'hFFFF_FFFF, 32'hFFFF_FF9C}, lat, bcy);

        // A start mid-calculation must be ignored.
        applyStimulus(1'b0, 32'd1000, 32'd33);
        repeat (8) @(negedge clk);
        bus.start     = 1'b1;
        bus.is_signed = 1'b1;
        bus.dividend  = 32'd5;
        bus.divisor   = 32'd5;
        @(negedge clk);
        bus.start = 1'b0;
        checkOutput("ignored_start", {1'b0, 32'd30, 32'd10}, lat, bcy);

        // Reset part-way through must abort with outputs cleared.
        applyStimulus(1'b0, 32'd77, 32'd3);
        repeat (18) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkValue("abort_quotient", bus.quotient, 32'd0);
        checkValue("abort_busy",     32'(bus.busy), 32'd0);
        dones = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        checkValue("abort_no_done", 32'(dones), 32'd0);

        // Randomized operands, with zero divisors and signed overflow mixed in.
        for (int i = 0; i < 25; i++) begin
            s = 1'($urandom);
            a = $urandom;
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2:       b = 32'($urandom_range(1, 15));
                3:       b = -32'($urandom_range(1, 15));
                default: b = $urandom >> $urandom_range(0, 31);
            endcase
            applyStimulus(s, a, b);
            checkOutput("random", ref_div(s, a, b), lat, bcy);
            checkValue("random_latency", 32'(lat), 32'd34);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        // Start held high with operands changing every cycle.
        @(negedge clk);
        bus.start = 1'b1;
        dones     = 0;
        repeat (175) begin
            @(negedge clk);
            if (bus.done) dones++;
            bus.is_signed = 1'($urandom);
            bus.dividend  = $urandom;
            bus.divisor   = ($urandom_range(0, 5) == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
        end
        bus.start = 1'b0;
        checkValue("b2b_done_count", 32'(dones), 32'd5);
        repeat (40) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
